// File: rtl/haui_wb_pkg.sv
// haui_wb_pkg: shared types and constants for the haui Wishbone arbiter.
//   arb_state_t  - arbiter FSM state (IDLE, GNT0, GNT1)
//   ARB_AW/DW    - default address/data widths
//   ARB_BAD_DATA - read data returned on a watchdog abort
//   arb_grant()  - one-hot grant vector for a given state
package haui_wb_pkg;

  localparam int unsigned ARB_AW = 32;
  localparam int unsigned ARB_DW = 32;

  localparam logic [31:0] ARB_BAD_DATA = 32'hBAD0_BAD0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // One-hot owner encoding as seen on grant_o (00 = idle).
  function automatic logic [1:0] arb_grant(input arb_state_t s);
    logic [1:0] g;
    g = 2'b00;
    case (s)
      GNT0:    g = 2'b01;
      GNT1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/haui_wb_watchdog.sv
// haui_wb_watchdog: aborts slave cycles that stay unacknowledged too long.
// Only built when HAUI_ARB_TIMEOUT_EN is defined.
//   clk_i, rst_ni - clock, async active-low reset
//   clr_i         - grant is changing on this edge; restart the count
//   pend_i        - granted strobe outstanding and not acked this cycle
//   abort_o       - one-cycle abort pulse, registered
//   timeout_o     - sticky "watchdog fired" flag, cleared only by reset
`ifdef HAUI_ARB_TIMEOUT_EN
module haui_wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic pend_i,
  output logic abort_o,
  output logic timeout_o
);

  localparam int unsigned CW = 16;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;
  logic          tmo_q, tmo_d;

  // Count consecutive pending cycles; the abort cycle itself restarts the count
  // so a master that keeps strobing after the error gets a fresh window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !pend_i || abort_q) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT)) begin
      cnt_d = cnt_q + CW'(1);
    end
    abort_d = (cnt_d == CW'(TIMEOUT));
    tmo_d   = tmo_q | abort_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      tmo_q   <= tmo_d;
    end
  end

  assign abort_o   = abort_q;
  assign timeout_o = tmo_q;

endmodule
`endif

// File: rtl/haui_wb_arbiter.sv
// haui_wb_arbiter: two-master / one-slave Wishbone classic arbiter.
// Round-robin on ties, bus locked to the owner for as long as its cyc is high.
// Optional watchdog (define HAUI_ARB_TIMEOUT_EN) terminates hung slave cycles
// with ack+err and sets a sticky timeout flag.
//   wb_clk_i, wb_rst_ni           - clock, async active-low reset
//   m0_*_i / m0_*_o               - master 0 (management SoC) request/response
//   m1_*_i / m1_*_o               - master 1 (debug/LA) request/response
//   s_*_o / s_ack_i, s_dat_i      - slave request/response
//   grant_o                       - registered one-hot owner, 00 = idle
//   timeout_o                     - sticky watchdog flag (0 when watchdog absent)
module haui_wb_arbiter
  import haui_wb_pkg::*;
#(
  parameter int unsigned AW      = ARB_AW,
  parameter int unsigned DW      = ARB_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DW-1:0]     m0_dat_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DW-1:0]     m1_dat_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic              s_ack_i,
  input  logic [DW-1:0]     s_dat_i,

  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  arb_state_t  state_q, state_d;
  logic        last_q, last_d;
  logic [1:0]  grant_q;
  logic        req_cyc, req_stb;
  logic        wdt_abort;
  logic [DW-1:0] rsp_dat;

  // Next-state: lock while the owner holds cyc; on release hand straight to
  // the other master if it is waiting; ties in IDLE go to the non-last master.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? GNT1 : IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? GNT0 : IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= arb_grant(state_d);
    end
  end

  assign grant_o = grant_q;

  // Request mux from the current owner; everything is 0 when idle.
  always_comb begin
    req_cyc = 1'b0;
    req_stb = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state_q)
      GNT0: begin
        req_cyc = m0_cyc_i;
        req_stb = m0_cyc_i & m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      GNT1: begin
        req_cyc = m1_cyc_i;
        req_stb = m1_cyc_i & m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // The abort cycle hides the request from the slave for that one cycle.
  assign s_cyc_o = req_cyc & ~wdt_abort;
  assign s_stb_o = req_stb & ~wdt_abort;

  // Response routing: only the owner sees ack/err/data, the other stalls.
  always_comb begin
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    rsp_dat  = wdt_abort ? DW'(ARB_BAD_DATA) : s_dat_i;
    case (state_q)
      GNT0: begin
        m0_ack_o = s_ack_i | wdt_abort;
        m0_err_o = wdt_abort;
        m0_dat_o = rsp_dat;
      end
      GNT1: begin
        m1_ack_o = s_ack_i | wdt_abort;
        m1_err_o = wdt_abort;
        m1_dat_o = rsp_dat;
      end
      default: ;
    endcase
  end

`ifdef HAUI_ARB_TIMEOUT_EN
  // Pending is judged on the un-gated request so the count reflects the master.
  haui_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .clr_i     (state_d != state_q),
    .pend_i    (req_cyc & req_stb & ~s_ack_i),
    .abort_o   (wdt_abort),
    .timeout_o (timeout_o)
  );
`else
  // No watchdog: a hung slave stalls its master indefinitely.
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT;
  assign wdt_abort  = 1'b0;
  assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_haui_wb_arbiter.sv
// tb_haui_wb_arbiter: directed stimulus with a per-cycle behavioural model of
// the arbiter (owner, round-robin pointer, pending-strobe streak) plus
// hand-computed literal expectations. Follows HAUI_ARB_TIMEOUT_EN if defined.
module tb_haui_wb_arbiter;

  localparam int TO = 4;
`ifdef HAUI_ARB_TIMEOUT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] wdat[2];
  logic        ack [2];
  logic        err [2];
  logic [31:0] rdat[2];

  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic        s_ack = 1'b0;
  logic [31:0] s_rdat = 32'h0;
  logic [1:0]  grant;
  logic        tmo;

  int n_chk = 0;
  int n_err = 0;

  haui_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),      .wb_rst_ni (rst_n),
    .m0_cyc_i (cyc[0]),   .m0_stb_i (stb[0]),   .m0_we_i (we[0]),
    .m0_sel_i (sel[0]),   .m0_adr_i (adr[0]),   .m0_dat_i (wdat[0]),
    .m0_ack_o (ack[0]),   .m0_err_o (err[0]),   .m0_dat_o (rdat[0]),
    .m1_cyc_i (cyc[1]),   .m1_stb_i (stb[1]),   .m1_we_i (we[1]),
    .m1_sel_i (sel[1]),   .m1_adr_i (adr[1]),   .m1_dat_i (wdat[1]),
    .m1_ack_o (ack[1]),   .m1_err_o (err[1]),   .m1_dat_o (rdat[1]),
    .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),    .s_we_o  (s_we),
    .s_sel_o  (s_sel),    .s_adr_o  (s_adr),    .s_dat_o (s_wdat),
    .s_ack_i  (s_ack),    .s_dat_i  (s_rdat),
    .grant_o  (grant),    .timeout_o (tmo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: -1 nobody, 0 or 1 = master index. last: index of the last master
  // to give up the bus. streak: consecutive cycles the owner has had a strobe
  // outstanding without ack.
  int owner = -1, last = 1, streak = 0;
  bit tmo_seen = 1'b0;
  int nxt_owner = -1, nxt_last = 1, nxt_streak = 0;
  bit nxt_tmo = 1'b0;

  function automatic int pick_owner(int own, bit c0, bit c1, int lst);
    bit c [2];
    c[0] = c0;
    c[1] = c1;
    if (own >= 0 && c[own]) return own;
    if (own >= 0) return c[1-own] ? 1 - own : -1;
    if (c0 && c1) return 1 - lst;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    bit ab, pend;
    logic [1:0]  e_grant;
    logic        e_cyc, e_stb, e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_dat;
    ab = WDT && owner >= 0 && streak == TO;
    e_grant = 2'b00;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_sel = '0; e_adr = '0; e_dat = '0;
    pend = 1'b0;
    if (owner >= 0) begin
      e_grant = (owner == 0) ? 2'b01 : 2'b10;
      e_cyc = cyc[owner] && !ab;
      e_stb = cyc[owner] && stb[owner] && !ab;
      e_we  = we[owner];
      e_sel = sel[owner];
      e_adr = adr[owner];
      e_dat = wdat[owner];
      pend  = cyc[owner] && stb[owner] && !s_ack;
    end
    chk("grant", grant, e_grant);
    chk("s_cyc", s_cyc, e_cyc);
    chk("s_stb", s_stb, e_stb);
    chk("s_we",  s_we,  e_we);
    chk("s_sel", s_sel, e_sel);
    chk("s_adr", s_adr, e_adr);
    chk("s_dat", s_wdat, e_dat);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d_ack", m), ack[m], (owner == m) && (s_ack || ab));
      chk($sformatf("m%0d_err", m), err[m], (owner == m) && ab);
      chk($sformatf("m%0d_dat", m), rdat[m], (owner == m) ? (ab ? BAD : s_rdat) : 32'h0);
    end
    chk("timeout", tmo, tmo_seen || ab);
    nxt_owner  = pick_owner(owner, cyc[0], cyc[1], last);
    nxt_last   = (owner >= 0 && nxt_owner != owner) ? owner : last;
    nxt_streak = (WDT && pend && !ab && nxt_owner == owner) ? streak + 1 : 0;
    nxt_tmo    = tmo_seen || ab;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1; last = 1; streak = 0; tmo_seen = 1'b0;
    end else begin
      owner = nxt_owner; last = nxt_last; streak = nxt_streak; tmo_seen = nxt_tmo;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    for (int m = 0; m < 2; m++) begin
      cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0;
      sel[m] = 4'h0; adr[m] = 32'h0; wdat[m] = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    bit seen;
    idle_masters();
    step();
    step();
    rst_n = 1'b1;
    step();
    // reset state
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_m0_ack", ack[0], 1'b0);
    chk("rst_m1_ack", ack[1], 1'b0);
    chk("rst_tmo", tmo, 1'b0);
    chk("rst_s_cyc", s_cyc, 1'b0);

    // single master write
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
    adr[0] = 32'h3000_0004; wdat[0] = 32'hCAFE_0001;
    #2 chk("wr_s_cyc_n", s_cyc, 1'b0);
    step();
    #2;
    chk("wr_s_cyc_n1", s_cyc, 1'b1);
    chk("wr_s_adr", s_adr, 32'h3000_0004);
    chk("wr_s_dat", s_wdat, 32'hCAFE_0001);
    chk("wr_grant", grant, 2'b01);
    chk("wr_ack_early", ack[0], 1'b0);
    step();
    s_ack = 1'b1;
    #2;
    chk("wr_m0_ack", ack[0], 1'b1);
    chk("wr_m1_ack", ack[1], 1'b0);
    step();
    idle_masters();
    s_ack = 1'b0;
    step();

    // tie after reset: m0 first, then m1 after one dead cycle
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h10;
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h20;
    step();
    s_ack = 1'b1; s_rdat = 32'h0000_A0A0;
    #2;
    chk("tie_grant0", grant, 2'b01);
    chk("tie_m0_ack", ack[0], 1'b1);
    chk("tie_m0_dat", rdat[0], 32'h0000_A0A0);
    step();
    cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b0;
    #2;
    chk("tie_dead_grant", grant, 2'b01);
    chk("tie_dead_s_cyc", s_cyc, 1'b0);
    step();
    #2;
    chk("tie_grant1", grant, 2'b10);
    chk("tie_s_adr1", s_adr, 32'h20);
    s_ack = 1'b1; s_rdat = 32'h0000_B1B1;
    #1;
    chk("tie_m1_ack", ack[1], 1'b1);
    chk("tie_m0_stall", ack[0], 1'b0);
    step();
    cyc[1] = 1'b0; stb[1] = 1'b0; s_ack = 1'b0;
    step();
    #2 chk("tie_idle", grant, 2'b00);
    cyc[0] = 1'b1; stb[0] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    step();
    #2 chk("tie2_grant0", grant, 2'b01);
    s_ack = 1'b1;
    step();
    idle_masters();
    s_ack = 1'b0;
    step();
    step();

    // bus lock: m1 keeps cyc across 3 strobes while m0 waits
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h40;
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h50;
    for (int i = 0; i < 3; i++) begin
      stb[1] = 1'b1; s_ack = 1'b1; s_rdat = 32'h1000 + 32'(i);
      #2;
      chk("lock_m1_ack", ack[1], 1'b1);
      chk("lock_m1_dat", rdat[1], 32'h1000 + 32'(i));
      chk("lock_m0_wait", ack[0], 1'b0);
      step();
      stb[1] = 1'b0; s_ack = 1'b0;
      #2 chk("lock_grant", grant, 2'b10);
      step();
    end
    cyc[1] = 1'b0;
    #2 chk("lock_dead", s_cyc, 1'b0);
    step();
    #2 chk("lock_m0_grant", grant, 2'b01);
    s_ack = 1'b1; s_rdat = 32'h0000_5A5A;
    #1 chk("lock_m0_ack", ack[0], 1'b1);
    step();
    idle_masters();
    s_ack = 1'b0;
    step();
    step();

    // hung slave
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h3000_0100;
    if (WDT) begin
      repeat (4) step();
      #2 chk("wdt_no_ack_yet", ack[0], 1'b0);
      step();
      #2;
      chk("wdt_ack", ack[0], 1'b1);
      chk("wdt_err", err[0], 1'b1);
      chk("wdt_dat", rdat[0], 32'hBAD0_BAD0);
      chk("wdt_tmo", tmo, 1'b1);
      chk("wdt_s_cyc", s_cyc, 1'b0);
      step();
      #2;
      chk("wdt_ack_1cyc", ack[0], 1'b0);
      chk("wdt_err_1cyc", err[0], 1'b0);
      chk("wdt_s_cyc_back", s_cyc, 1'b1);
      chk("wdt_tmo_sticky", tmo, 1'b1);
    end else begin
      seen = 1'b0;
      repeat (1000) begin
        step();
        #2 seen = seen | ack[0];
      end
      chk("hung_no_ack", seen, 1'b0);
      chk("hung_no_tmo", tmo, 1'b0);
    end
    idle_masters();
    step();
    step();

    // reset asserted while m1 owns the bus
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h60;
    step();
    #2;
    chk("rstmid_grant1", grant, 2'b10);
    chk("rstmid_s_cyc_pre", s_cyc, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_s_cyc", s_cyc, 1'b0);
    chk("rstmid_grant", grant, 2'b00);
    chk("rstmid_tmo", tmo, 1'b0);
    idle_masters();
    step();
    step();
    rst_n = 1'b1;
    step();
    #2 chk("rstmid_after", grant, 2'b00);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
